v2p_chnl_grant_queue: RTL
=========================

// Module: v2p_chnl_grant_queue
// PURPOSE
//  Parametrised successor to the single-entry selected-channel register between req_scheduler and MPT/MTT.
//  Queues up to GRANT_DEPTH one-hot channel grants from req_scheduler and presents the head grant to MPT.
//  Keeps a per-channel pending mask so the scheduler never double-grants a channel.
//  Rejects illegal grants and reports them.
// PARAMETERS
//  CHNL_NUM     8   number of requesting channels (one-hot width), >=2
//  GRANT_DEPTH  2   queue entries, power of 2, >=2
//  WDOG_W       12  watchdog counter width (used only with V2P_CHCTL_WDOG_EN)
// PORTS
//  clk            in   1                    clock
//  rst            in   1                    reset, asynchronous, active-high
//  grant_valid    in   1                    scheduler offers grant
//  grant_chnl     in   CHNL_NUM             one-hot channel of offered grant
//  grant_ready    out  1                    queue accepts grant (= !full)
//  sel_valid      out  1                    head grant present
//  sel_chnl       out  CHNL_NUM             head grant; all-zero when !sel_valid
//  req_read       in   1                    MPT has consumed head (pop)
//  chnl_pending   out  CHNL_NUM             OR of all queued grants
//  occupancy      out  log2(GRANT_DEPTH)+1  number of queued grants
//  err_clr        in   1                    clears sticky error flags
//  err_illegal    out  1                    sticky: zero or multi-hot grant seen
//  err_dup        out  1                    sticky: grant for an already pending channel
//  err_underflow  out  1                    sticky: req_read while empty
//  wdog_expired   out  1                    sticky: head dropped by watchdog
// BEHAVIOUR
//  - Reset: queue empty, occupancy=0, grant_ready=1, sel_valid=0, sel_chnl=0, chnl_pending=0, all err_* and wdog_expired=0, watchdog=0.
//  - Push: grant_valid & grant_ready at clock edge.
//    - Legal grant: exactly one bit set, and not in chnl_pending. Legal grant is written at tail.
//    - Legal grant is visible on sel_* the next cycle when the queue was empty. Latency is 1.
//  - Illegal grant: handshake completes, entry dropped, err_illegal set.
//  - Duplicate grant: one-hot but bit already in chnl_pending. Handshake completes, entry dropped, err_dup set.
//  - Pop: req_read & sel_valid removes head at clock edge. The next entry appears on sel_* the following cycle.
//  - Combinational mask: in any cycle with req_read=1, sel_valid and sel_chnl are forced to 0. Same-cycle re-sampling by MPT is impossible.
//  - req_read with empty queue: ignored, err_underflow set.
//  - Simultaneous push+pop, not full: occupancy unchanged. Pointers wrap modulo GRANT_DEPTH.
//    - chnl_pending drops the head bit and adds the new bit in the same edge.
//    - Pushing the channel being popped in that same cycle counts as a duplicate: dropped, err_dup set.
//  - Full: grant_ready=0 and no push, even if a pop occurs in that cycle. There is no ready pass-through path.
//  - chnl_pending and occupancy are registered and updated at the same edge as the queue.
//  - Sticky flags: err_clr clears all flags. A flag set and cleared in the same cycle ends up set.
//  - Reset mid-operation: all entries discarded immediately. The asynchronous reset has no drain.
// CONFIGURATION
//  V2P_CHCTL_WDOG_EN defined:
//    - WDOG_W-bit counter increments each cycle sel_valid=1 with no req_read. It resets to 0 on pop or on empty.
//    - At all-ones the head is force-popped on the next edge and wdog_expired is set.
//    - A forced pop updates chnl_pending like a normal pop.
//  V2P_CHCTL_WDOG_EN undefined:
//    - No counter exists. wdog_expired is tied to 0. WDOG_W is unused.
// STRUCTURE
//  - Shared define header holds:
//    - channel index constants (CEU, DB_WQE, WP_WQE, WP_DATA, RTC_CQ, RRC_DATA, EE_RQWQE, EE_DATA)
//    - V2P_CHNL_NUM
//    - the error-flag bit order.
//  - One sub-module, v2p_chctl_grant_fifo: a generic GRANT_DEPTH x CHNL_NUM register FIFO with push/pop/full/empty/count.
//  - The top level owns legality checks, the pending mask, sticky flags, the watchdog and output masking.
// TESTING (CHNL_NUM=8, GRANT_DEPTH=2, WDOG_W=4)
//  1. Push 0x04, then 0x10 on consecutive cycles.
//     -> sel_chnl=0x04 one cycle after the first push, chnl_pending=0x14, occupancy=2, grant_ready=0.
//  2. Continue from (1): req_read=1 for one cycle.
//     -> sel_valid=0 during that cycle, then sel_chnl=0x10, chnl_pending=0x10, occupancy=1.
//  3. Push 0x00, then 0x06, then 0x10 while 0x10 is pending.
//     -> nothing queued, err_illegal=1, err_dup=1.
//     -> err_clr clears both flags the next cycle.
//  4. One entry 0x01 queued. Same cycle: push 0x80 and req_read.
//     -> occupancy stays 1, sel_chnl=0x80, chnl_pending=0x80.
//  5. Empty queue, req_read=1 -> err_underflow=1, occupancy stays 0.
//     Then assert rst mid-queue with 2 entries -> all outputs return to reset values immediately.
//  6. WDOG_EN: queue 0x02, hold req_read=0 -> after 15 idle cycles plus one edge, entry dropped, wdog_expired=1, chnl_pending=0.
//     Without the macro: entry stays queued and wdog_expired stays 0.

Source files
------------

// File: rtl/v2p_chnl_grant_queue_pkg.sv
// rtl/v2p_chnl_grant_queue_pkg.sv - shared channel indices and error-flag layout
// Channel order matches the req_scheduler one-hot grant bit positions.
package v2p_chnl_grant_queue_pkg;

  localparam int V2P_CHNL_NUM = 8;

  localparam int CEU      = 0;
  localparam int DB_WQE   = 1;
  localparam int WP_WQE   = 2;
  localparam int WP_DATA  = 3;
  localparam int RTC_CQ   = 4;
  localparam int RRC_DATA = 5;
  localparam int EE_RQWQE = 6;
  localparam int EE_DATA  = 7;

  localparam int ERR_ILLEGAL_BIT   = 0;
  localparam int ERR_DUP_BIT       = 1;
  localparam int ERR_UNDERFLOW_BIT = 2;
  localparam int ERR_WDOG_BIT      = 3;
  localparam int ERR_NUM           = 4;

endpackage

// File: rtl/v2p_chctl_grant_fifo.sv
// rtl/v2p_chctl_grant_fifo.sv - generic DEPTH x WIDTH register FIFO
// Head is read straight from storage, so a push into an empty FIFO shows one cycle later.
module v2p_chctl_grant_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [WIDTH-1:0]         wdata_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [PW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == FULL_CNT);
  assign empty_o = (count_q == '0);
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  always_comb begin
    count_d = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  // Storage needs no reset: entries are only observable through count_q.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/v2p_chnl_grant_queue.sv
// rtl/v2p_chnl_grant_queue.sv - queued one-hot channel grants from req_scheduler to MPT/MTT
// Optional head watchdog enabled by V2P_CHCTL_WDOG_EN.
module v2p_chnl_grant_queue
  import v2p_chnl_grant_queue_pkg::*;
#(
  parameter int CHNL_NUM    = V2P_CHNL_NUM,
  parameter int GRANT_DEPTH = 2,
  parameter int WDOG_W      = 12
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           grant_valid,
  input  logic [CHNL_NUM-1:0]            grant_chnl,
  output logic                           grant_ready,
  output logic                           sel_valid,
  output logic [CHNL_NUM-1:0]            sel_chnl,
  input  logic                           req_read,
  output logic [CHNL_NUM-1:0]            chnl_pending,
  output logic [$clog2(GRANT_DEPTH):0]   occupancy,
  input  logic                           err_clr,
  output logic                           err_illegal,
  output logic                           err_dup,
  output logic                           err_underflow,
  output logic                           wdog_expired
);

  logic [CHNL_NUM-1:0]              head;
  logic                             fifo_full, fifo_empty;
  logic [$clog2(GRANT_DEPTH):0]     fifo_count;
  logic [CHNL_NUM-1:0]              pending_q, pending_d;
  logic [ERR_NUM-1:0]               err_q, err_d, err_set;
  logic                             push_hs, is_onehot, is_dup, push_ok, pop, wdog_pop;

  assign grant_ready = ~fifo_full;
  assign push_hs     = grant_valid & ~fifo_full;
  assign is_onehot   = (grant_chnl != '0) && ((grant_chnl & (grant_chnl - 1'b1)) == '0);
  // Pending still holds the head being popped, so re-granting it this cycle is a duplicate.
  assign is_dup      = |(grant_chnl & pending_q);
  assign push_ok     = push_hs & is_onehot & ~is_dup;
  assign pop         = ~fifo_empty & (req_read | wdog_pop);

  v2p_chctl_grant_fifo #(
    .DEPTH (GRANT_DEPTH),
    .WIDTH (CHNL_NUM)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push_ok),
    .pop_i   (pop),
    .wdata_i (grant_chnl),
    .rdata_o (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  always_comb begin
    pending_d = pending_q;
    if (pop)     pending_d = pending_d & ~head;
    if (push_ok) pending_d = pending_d | grant_chnl;
    err_set                    = '0;
    err_set[ERR_ILLEGAL_BIT]   = push_hs & ~is_onehot;
    err_set[ERR_DUP_BIT]       = push_hs & is_onehot & is_dup;
    err_set[ERR_UNDERFLOW_BIT] = req_read & fifo_empty;
    err_set[ERR_WDOG_BIT]      = wdog_pop;
    err_d = (err_q & ~{ERR_NUM{err_clr}}) | err_set;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending_q <= '0;
      err_q     <= '0;
    end else begin
      pending_q <= pending_d;
      err_q     <= err_d;
    end
  end

`ifdef V2P_CHCTL_WDOG_EN
  logic [WDOG_W-1:0] wdog_q, wdog_d;

  assign wdog_pop = ~fifo_empty & ~req_read & (&wdog_q);

  always_comb begin
    wdog_d = wdog_q;
    if (fifo_empty || pop) wdog_d = '0;
    else if (!req_read)    wdog_d = wdog_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) wdog_q <= '0;
    else     wdog_q <= wdog_d;
  end
`else
  logic [WDOG_W-1:0] unused_wdog_w;
  assign unused_wdog_w = '0;
  assign wdog_pop      = 1'b0;
`endif

  // MPT must never re-sample the head in the cycle it consumes it.
  assign sel_valid     = ~fifo_empty & ~req_read;
  assign sel_chnl      = sel_valid ? head : '0;
  assign chnl_pending  = pending_q;
  assign occupancy     = fifo_count;
  assign err_illegal   = err_q[ERR_ILLEGAL_BIT];
  assign err_dup       = err_q[ERR_DUP_BIT];
  assign err_underflow = err_q[ERR_UNDERFLOW_BIT];
  assign wdog_expired  = err_q[ERR_WDOG_BIT];

endmodule
